// File: rtl/burst_ram_arbiter.sv
// N-port BurstRAM arbiter: round-robin or fixed-priority ownership that is held
// until the owner is idle and every read beat it asked for has come back.
module burst_ram_arbiter #(
    parameter int NUM_PORTS               = 2,
    parameter int RAM_DEPTH_BITWIDTH      = 4,
    parameter int RAM_BURST_DATA_BITWIDTH = 64,
    parameter int RAM_BURST_DATA_COUNT    = 4,
    parameter bit FIXED_PRIORITY          = 1'b0
) (
    input  logic                                         clk,
    input  logic                                         rst_n,
    input  logic [NUM_PORTS-1:0]                         cl_req,
    input  logic [NUM_PORTS-1:0]                         cl_busy,
    output logic [NUM_PORTS-1:0]                         cl_gnt,
    input  logic [NUM_PORTS-1:0]                         cl_cmd,
    input  logic [NUM_PORTS-1:0]                         cl_cmd_en,
    input  logic [NUM_PORTS*RAM_DEPTH_BITWIDTH-1:0]      cl_addr,
    input  logic [NUM_PORTS*RAM_BURST_DATA_BITWIDTH-1:0] cl_wr_data,
    input  logic [NUM_PORTS*RAM_BURST_DATA_BITWIDTH/8-1:0] cl_data_mask,
    output logic [RAM_BURST_DATA_BITWIDTH-1:0]           cl_rd_data,
    output logic [NUM_PORTS-1:0]                         cl_rd_valid,
    output logic [NUM_PORTS-1:0]                         cl_br_busy,
    output logic                                         br_cmd,
    output logic                                         br_cmd_en,
    output logic [RAM_DEPTH_BITWIDTH-1:0]                br_addr,
    output logic [RAM_BURST_DATA_BITWIDTH-1:0]           br_wr_data,
    output logic [RAM_BURST_DATA_BITWIDTH/8-1:0]         br_data_mask,
    input  logic [RAM_BURST_DATA_BITWIDTH-1:0]           br_rd_data,
    input  logic                                         br_rd_data_valid,
    input  logic                                         br_busy
);
    localparam int N  = NUM_PORTS;
    localparam int AW = RAM_DEPTH_BITWIDTH;
    localparam int DW = RAM_BURST_DATA_BITWIDTH;
    localparam int MW = DW / 8;
    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam int PW = $clog2(2 * RAM_BURST_DATA_COUNT + 1);
    localparam logic [PW:0] C_CNT = (PW+1)'(RAM_BURST_DATA_COUNT);
    localparam logic [PW:0] C_MAX = (PW+1)'(2 * RAM_BURST_DATA_COUNT);

    typedef enum logic {S_IDLE, S_GRANTED} state_t;

    state_t          r_state;
    logic [N-1:0]    r_gnt;
    logic [IW-1:0]   r_owner;
    logic [IW-1:0]   r_rr_last;
    logic [PW-1:0]   r_pending;

    logic [IW:0]     w_sum  [N];
    logic [IW:0]     w_wrap [N];
    logic [IW-1:0]   w_scan [N];
    logic [IW-1:0]   w_win;
    logic            w_found;
    logic            w_rd_cmd;
    logic            w_rel;
    logic [PW:0]     w_add;
    logic [PW:0]     w_pnext;

    // Round-robin scan order: rr_last+1, rr_last+2, ... wrapped mod N
    for (genvar k = 0; k < N; k++) begin : g_scan
        assign w_sum[k]  = {1'b0, r_rr_last} + (IW+1)'(k + 1);
        assign w_wrap[k] = (w_sum[k] >= (IW+1)'(N)) ? w_sum[k] - (IW+1)'(N) : w_sum[k];
        assign w_scan[k] = w_wrap[k][IW-1:0];
    end

    always_comb begin
        w_win   = '0;
        w_found = 1'b0;
        if (FIXED_PRIORITY) begin
            for (int i = N - 1; i >= 0; i--) begin
                if (cl_req[i]) begin
                    w_win   = IW'(i);
                    w_found = 1'b1;
                end
            end
        end else begin
            for (int k = 0; k < N; k++) begin
                if (!w_found && cl_req[w_scan[k]]) begin
                    w_win   = w_scan[k];
                    w_found = 1'b1;
                end
            end
        end
    end

    always_comb begin
        br_cmd       = 1'b0;
        br_cmd_en    = 1'b0;
        br_addr      = '0;
        br_wr_data   = '0;
        br_data_mask = '0;
        for (int i = 0; i < N; i++) begin
            if (r_gnt[i]) begin
                br_cmd       = cl_cmd[i];
                br_cmd_en    = cl_cmd_en[i];
                br_addr      = cl_addr[i*AW +: AW];
                br_wr_data   = cl_wr_data[i*DW +: DW];
                br_data_mask = cl_data_mask[i*MW +: MW];
            end
        end
    end

    assign cl_gnt      = r_gnt;
    assign cl_rd_data  = br_rd_data;
    assign cl_rd_valid = r_gnt & {N{br_rd_data_valid}};
    assign cl_br_busy  = ~r_gnt | (r_gnt & {N{br_busy}});

    assign w_rd_cmd = br_cmd_en && !br_cmd;

    // A read issued this very cycle also blocks release, its beats are owed
    assign w_rel = !cl_req[r_owner] && !cl_busy[r_owner] &&
                   (r_pending == '0) && !w_rd_cmd && !br_busy;

    always_comb begin
        w_add = {1'b0, r_pending} + (w_rd_cmd ? C_CNT : '0);
        if (br_rd_data_valid && (w_add != '0))
            w_pnext = w_add - 1'b1;
        else
            w_pnext = w_add;
        if (w_pnext > C_MAX)
            w_pnext = C_MAX;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_gnt     <= '0;
            r_owner   <= '0;
            r_pending <= '0;
            r_rr_last <= IW'(N - 1);
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_gnt     <= N'(1) << w_win;
                        r_owner   <= w_win;
                        r_rr_last <= w_win;
                        r_state   <= S_GRANTED;
                    end
                end
                S_GRANTED: begin
                    r_pending <= w_pnext[PW-1:0];
                    if (w_rel) begin
                        r_gnt   <= '0;
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule
